// File: rtl/event_timestamper.sv
// Timestamps rising edges of event_in with the current count_in value and queues them
// in a show-ahead FIFO drained by a valid/ready handshake; dropped events are counted.
module event_timestamper #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TS_W-1:0]          count_in,
  input  logic                     event_in,
  output logic [TS_W-1:0]          ts_data,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               ovf_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic              event_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]        ovf_q, ovf_d;
  logic [TS_W-1:0]   mem_q [DEPTH];

  logic rise, empty, full, push, pop;

  always_comb begin
    rise  = event_in & ~event_q;
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop   = ~empty & ts_ready;
    // A pop frees the head slot this cycle, so a full FIFO can still accept the edge.
    push  = rise & (~full | pop);

    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;

    ovf_d = ovf_q;
    if (rise && full && !pop && (ovf_q != 8'hff)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
    end else begin
      event_q  <= event_in;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= count_in;
      end
    end
  end

  // Storage is not reset; the head is gated to zero while empty instead.
  always_comb begin
    ts_valid  = ~empty;
    ts_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    level     = wr_ptr_q - rd_ptr_q;
    ovf_count = ovf_q;
  end

endmodule

// File: tb/tb_event_timestamper.sv
// Self-checking bench for event_timestamper: queue-based scoreboard on every cycle plus
// a table of hand-computed vectors and short hand-written corner-case sequences.
module tb_event_timestamper;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] count_in = '0;
  logic        event_in = 1'b1;
  logic        ts_ready = 1'b0;
  logic [63:0] ts_data;
  logic        ts_valid;
  logic [2:0]  level;
  logic [7:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [63:0] exp_q[$];
  int          exp_ovf = 0;
  logic        prev_ev = 1'b1;

  typedef struct {
    logic        r;
    logic        e;
    logic        rd;
    logic [63:0] c;
    logic        v;
    int          lvl;
    logic [63:0] d;
    int          ovf;
  } vec_t;

  vec_t vecs[$];

  event_timestamper #(.DEPTH(DEPTH), .TS_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_in  (count_in),
    .event_in  (event_in),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .level     (level),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, update the scoreboard, then compare DUT state after the edge.
  task automatic step(input logic r, input logic e, input logic rd, input logic [63:0] c);
    logic rise, pop, full;
    rst_n = r; event_in = e; ts_ready = rd; count_in = c;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_q.delete();
      exp_ovf = 0;
      prev_ev = 1'b1;
    end else begin
      rise = e && !prev_ev;
      pop  = (exp_q.size() != 0) && rd;
      full = (exp_q.size() == DEPTH);
      if (pop) void'(exp_q.pop_front());
      if (rise) begin
        if (!full || pop) exp_q.push_back(c);
        else if (exp_ovf < 255) exp_ovf++;
      end
      prev_ev = e;
    end
    chk("sb_valid", 64'(ts_valid), 64'(exp_q.size() != 0));
    chk("sb_level", 64'(level), 64'(exp_q.size()));
    chk("sb_ovf", 64'(ovf_count), 64'(exp_ovf));
    chk("sb_data", ts_data, (exp_q.size() != 0) ? exp_q[0] : 64'd0);
  endtask

  function automatic void add(input logic e, input logic rd, input logic [63:0] c,
                              input logic v, input int lvl, input logic [63:0] d,
                              input int ovf);
    vec_t t;
    t.r = 1'b1; t.e = e; t.rd = rd; t.c = c;
    t.v = v; t.lvl = lvl; t.d = d; t.ovf = ovf;
    vecs.push_back(t);
  endfunction

  initial begin
    // Single capture and drain
    add(0, 0,  99, 0, 0,   0, 0);
    add(1, 0, 100, 1, 1, 100, 0);
    add(0, 1, 101, 0, 0,   0, 0);
    // Fill and overflow
    add(1, 0, 10, 1, 1, 10, 0);
    add(0, 0, 11, 1, 1, 10, 0);
    add(1, 0, 20, 1, 2, 10, 0);
    add(0, 0, 21, 1, 2, 10, 0);
    add(1, 0, 30, 1, 3, 10, 0);
    add(0, 0, 31, 1, 3, 10, 0);
    add(1, 0, 40, 1, 4, 10, 0);
    add(0, 0, 41, 1, 4, 10, 0);
    add(1, 0, 50, 1, 4, 10, 1);
    add(0, 0, 51, 1, 4, 10, 1);
    add(0, 1, 52, 1, 3, 20, 1);
    add(0, 1, 53, 1, 2, 30, 1);
    add(0, 1, 54, 1, 1, 40, 1);
    add(0, 1, 55, 0, 0,  0, 1);
    // Refill, then edge while full with a simultaneous pop
    add(1, 0, 10, 1, 1, 10, 1);
    add(0, 0, 11, 1, 1, 10, 1);
    add(1, 0, 20, 1, 2, 10, 1);
    add(0, 0, 21, 1, 2, 10, 1);
    add(1, 0, 30, 1, 3, 10, 1);
    add(0, 0, 31, 1, 3, 10, 1);
    add(1, 0, 40, 1, 4, 10, 1);
    add(0, 0, 41, 1, 4, 10, 1);
    add(1, 1, 60, 1, 4, 20, 1);
    add(0, 1, 61, 1, 3, 30, 1);
    add(0, 1, 62, 1, 2, 40, 1);
    add(0, 1, 63, 1, 1, 60, 1);
    add(0, 1, 64, 0, 0,  0, 1);

    // Reset with event held high: nothing captured
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'(i));
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 64'(i + 3));
      chk("rst_hold_valid", 64'(ts_valid), 64'd0);
      chk("rst_hold_level", 64'(level), 64'd0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].e, vecs[i].rd, vecs[i].c);
      chk($sformatf("vec%0d_valid", i), 64'(ts_valid), 64'(vecs[i].v));
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].lvl));
      chk($sformatf("vec%0d_data", i), ts_data, vecs[i].d);
      chk($sformatf("vec%0d_ovf", i), 64'(ovf_count), 64'(vecs[i].ovf));
    end

    // 1,0,1 pattern gives two entries
    step(1, 1, 0, 200);
    step(1, 0, 0, 201);
    step(1, 1, 0, 202);
    step(1, 0, 0, 203);
    chk("pat101_level", 64'(level), 64'd2);
    chk("pat101_head", ts_data, 64'd200);
    step(1, 0, 1, 204);
    chk("pat101_second", ts_data, 64'd202);
    step(1, 0, 1, 205);

    // Level held high for 5 cycles gives one entry
    for (int i = 0; i < 5; i++) step(1, 1, 0, 64'(300 + i));
    step(1, 0, 0, 305);
    chk("hold_level", 64'(level), 64'd1);
    chk("hold_data", ts_data, 64'd300);

    // Head stable while not ready
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 64'(400 + i));
      chk("stable_data", ts_data, 64'd300);
    end
    step(1, 0, 1, 410);
    chk("stable_drained", 64'(ts_valid), 64'd0);

    // Ready while empty has no effect
    step(1, 0, 1, 411);
    chk("empty_pop_level", 64'(level), 64'd0);

    // Counter wrap is stored verbatim
    step(1, 1, 0, 64'hffff_ffff_ffff_ffff);
    step(1, 0, 0, 64'd0);
    step(1, 1, 0, 64'd1);
    step(1, 0, 1, 64'd2);
    chk("wrap_second", ts_data, 64'd1);
    step(1, 0, 1, 64'd3);

    // Saturation: fill then 300 dropped edges
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 0, 64'(i));
      step(1, 0, 0, 64'(i + 100));
    end
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 0, 64'(1000 + i));
      step(1, 0, 0, 64'(2000 + i));
    end
    chk("sat_ovf", 64'(ovf_count), 64'd255);
    chk("sat_level", 64'(level), 64'd4);
    chk("sat_head", ts_data, 64'd1);

    // Mid-operation reset with a coincident edge
    step(0, 1, 0, 64'd5);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_valid", 64'(ts_valid), 64'd0);
    chk("midrst_ovf", 64'(ovf_count), 64'd0);
    step(1, 1, 0, 64'd6);
    chk("midrst_noedge", 64'(ts_valid), 64'd0);
    step(1, 0, 0, 64'd6);
    step(1, 1, 0, 64'd7);
    chk("post_rst_data", ts_data, 64'd7);
    chk("post_rst_level", 64'(level), 64'd1);
    step(1, 0, 1, 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
